// File: rtl/rename_map_ckpt.sv
// Register-rename map table with intra-group bypass, per-PR ready bits and
// branch checkpoints that restore the whole map in a single cycle.
module rename_map_ckpt #(
    parameter  int N_WAY     = 2,
    parameter  int ARCH_REGS = 32,
    parameter  int PHYS_REGS = 64,
    parameter  int N_CKPT    = 4,
    localparam int AW        = $clog2(ARCH_REGS),
    localparam int PW        = $clog2(PHYS_REGS),
    localparam int CW        = $clog2(N_CKPT)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_WAY-1:0]    dis_valid,
    input  logic [N_WAY*AW-1:0] dis_dest,
    input  logic [N_WAY*AW-1:0] dis_src1,
    input  logic [N_WAY*AW-1:0] dis_src2,
    input  logic [N_WAY*PW-1:0] dis_newpr,
    input  logic [N_WAY-1:0]    dis_branch,
    output logic                dis_ready,
    output logic [CW-1:0]       dis_ckpt_id,
    output logic [N_WAY*PW-1:0] src1_pr,
    output logic [N_WAY-1:0]    src1_rdy,
    output logic [N_WAY*PW-1:0] src2_pr,
    output logic [N_WAY-1:0]    src2_rdy,
    output logic [N_WAY*PW-1:0] old_pr,
    input  logic [N_WAY-1:0]    cdb_valid,
    input  logic [N_WAY*PW-1:0] cdb_pr,
    input  logic                squash,
    input  logic [CW-1:0]       squash_id,
    input  logic                ckpt_free,
    output logic                ckpt_full
);

    // Checkpoints are flops, not RAM: a restore reads every entry at once.
    logic [PW-1:0]        map_reg  [ARCH_REGS];
    logic [PW-1:0]        map_next [ARCH_REGS];
    logic [PW-1:0]        ckpt_val [ARCH_REGS];
    logic [PW-1:0]        ckpt_reg [N_CKPT][ARCH_REGS];
    logic [PHYS_REGS-1:0] ready_reg, ready_next;
    logic [CW-1:0]        head_reg, tail_reg, head_after;
    logic [CW:0]          count_reg, count_after;
    logic                 free_ok, has_br, accept_br, past_br;
    logic [N_WAY-1:0]     br_vec, renames, s1_byp, s2_byp;
    logic [AW-1:0]        dest [N_WAY];
    logic [AW-1:0]        src1 [N_WAY];
    logic [AW-1:0]        src2 [N_WAY];
    logic [PW-1:0]        newpr [N_WAY];
    logic [PW-1:0]        cdbpr [N_WAY];
    logic [PW-1:0]        s1_pr [N_WAY];
    logic [PW-1:0]        s2_pr [N_WAY];
    logic [PW-1:0]        o_pr  [N_WAY];

    function automatic logic cdb_hit(input logic [PW-1:0] pr);
        cdb_hit = 1'b0;
        for (int w = 0; w < N_WAY; w++)
            if (cdb_valid[w] && cdbpr[w] == pr) cdb_hit = 1'b1;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < N_WAY; gi++) begin : g_slot
            assign dest[gi]  = dis_dest[gi*AW +: AW];
            assign src1[gi]  = dis_src1[gi*AW +: AW];
            assign src2[gi]  = dis_src2[gi*AW +: AW];
            assign newpr[gi] = dis_newpr[gi*PW +: PW];
            assign cdbpr[gi] = cdb_pr[gi*PW +: PW];
            assign renames[gi] = dis_valid[gi] && (dest[gi] != '0);
            assign src1_pr[gi*PW +: PW] = s1_pr[gi];
            assign src2_pr[gi*PW +: PW] = s2_pr[gi];
            assign old_pr[gi*PW +: PW]  = o_pr[gi];
            assign src1_rdy[gi] = !s1_byp[gi] && (ready_reg[s1_pr[gi]] || cdb_hit(s1_pr[gi]));
            assign src2_rdy[gi] = !s2_byp[gi] && (ready_reg[s2_pr[gi]] || cdb_hit(s2_pr[gi]));
        end
    endgenerate

    // Later matching slots overwrite earlier ones, so the youngest older writer wins.
    always_comb begin
        s1_byp = '0;
        s2_byp = '0;
        for (int n = 0; n < N_WAY; n++) begin
            s1_pr[n] = map_reg[src1[n]];
            s2_pr[n] = map_reg[src2[n]];
            o_pr[n]  = map_reg[dest[n]];
            for (int k = 0; k < n; k++) begin
                if (renames[k]) begin
                    if (dest[k] == src1[n]) begin
                        s1_pr[n]  = newpr[k];
                        s1_byp[n] = 1'b1;
                    end
                    if (dest[k] == src2[n]) begin
                        s2_pr[n]  = newpr[k];
                        s2_byp[n] = 1'b1;
                    end
                    if (dest[k] == dest[n]) o_pr[n] = newpr[k];
                end
            end
            if (dest[n] == '0) o_pr[n] = '0;
        end
    end

    assign br_vec      = dis_valid & dis_branch;
    assign has_br      = |br_vec;
    assign ckpt_full   = (count_reg == (CW+1)'(N_CKPT));
    assign dis_ready   = !squash && !(ckpt_full && has_br);
    assign accept_br   = dis_ready && has_br;
    assign dis_ckpt_id = tail_reg;
    assign free_ok     = ckpt_free && (count_reg != '0);
    assign head_after  = head_reg + CW'(free_ok);
    assign count_after = count_reg - (CW+1)'(free_ok);

    // The snapshot stops taking renames once the branch slot has been passed.
    always_comb begin
        map_next = map_reg;
        ckpt_val = map_reg;
        past_br  = 1'b0;
        for (int k = 0; k < N_WAY; k++) begin
            if (renames[k]) begin
                map_next[dest[k]] = newpr[k];
                if (!past_br) ckpt_val[dest[k]] = newpr[k];
            end
            if (br_vec[k]) past_br = 1'b1;
        end
    end

    // CDB sets first so a same-cycle dispatch clear of that PR wins.
    always_comb begin
        ready_next = ready_reg;
        for (int w = 0; w < N_WAY; w++)
            if (cdb_valid[w]) ready_next[cdbpr[w]] = 1'b1;
        if (dis_ready)
            for (int k = 0; k < N_WAY; k++)
                if (renames[k]) ready_next[newpr[k]] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) map_reg[i] <= PW'(i);
            ready_reg <= '1;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            ready_reg <= ready_next;
            head_reg  <= head_after;
            if (squash) begin
                map_reg   <= ckpt_reg[squash_id];
                tail_reg  <= squash_id + CW'(1);
                count_reg <= {1'b0, squash_id - head_after} + (CW+1)'(1);
            end else begin
                if (dis_ready) map_reg <= map_next;
                if (accept_br) begin
                    tail_reg  <= tail_reg + CW'(1);
                    count_reg <= count_after + (CW+1)'(1);
                end else begin
                    count_reg <= count_after;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept_br) ckpt_reg[tail_reg] <= ckpt_val;
    end

endmodule
